// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches that drive detectors with it.
package serial_pattern_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] PATTERN_58 = 8'h58;

endpackage

// File: rtl/serial_pattern_tx_shreg.sv
// WIDTH-bit shift register: parallel load has priority over shift-left, zero fills the LSB.
module tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = r_q << 1;
  assign o_q       = r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_q <= '0;
    else if (i_load)  r_q <= i_din;
    else if (i_shift) r_q <= w_shifted;
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: sends a word MSB-first, repeated back-to-back, with gapless frame chaining.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  output logic             load_ready,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_sh_q, w_sh_din;
  logic [BW-1:0]    r_bit_cnt, w_bit_nxt;
  logic [CNT_W-1:0] r_reps, w_reps_nxt;
  logic             r_done, w_done_nxt;
  logic             w_sh_load, w_sh_shift;
  logic             w_last, w_accept;

  // r_bit_cnt indexes the bit currently on out; r_reps counts repetitions left including the current one.
  assign w_last     = (r_state == SHIFT) && (r_bit_cnt == LAST) && (r_reps == CNT_W'(1));
  assign load_ready = !abort && ((r_state == IDLE) || w_last);
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_reps_nxt  = r_reps;
    w_sh_load   = 1'b0;
    w_sh_shift  = 1'b0;
    w_sh_din    = '0;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_sh_load   = 1'b1;
      w_sh_din    = load_data;
      w_bit_nxt   = '0;
      w_reps_nxt  = (load_count == '0) ? CNT_W'(1) : load_count;
    end else if (r_state == SHIFT) begin
      if (abort || w_last) begin
        // Loading zeros on exit keeps out low while idle.
        w_state_nxt = IDLE;
        w_sh_load   = 1'b1;
        w_bit_nxt   = '0;
        w_reps_nxt  = '0;
      end else if (r_bit_cnt == LAST) begin
        w_sh_load  = 1'b1;
        w_sh_din   = r_hold;
        w_bit_nxt  = '0;
        w_reps_nxt = r_reps - CNT_W'(1);
      end else begin
        w_sh_shift = 1'b1;
        w_bit_nxt  = r_bit_cnt + BW'(1);
      end
    end
    w_done_nxt = (w_state_nxt == SHIFT) && (w_bit_nxt == LAST) && (w_reps_nxt == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_bit_cnt <= '0;
      r_reps    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_reps    <= w_reps_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) r_hold <= load_data;
    end
  end

  tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_sh_load),
    .i_shift (w_sh_shift),
    .i_din   (w_sh_din),
    .o_q     (w_sh_q)
  );

  assign out       = w_sh_q[WIDTH-1];
  assign out_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized bench for serial_pattern_tx with a queue-based frame model and a behavioural 0x58 detector.
module tb_serial_pattern_tx;
  import serial_pattern_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic [3:0] load_count = '0;
  logic       abort = 1'b0;
  logic       load_ready, out, out_valid, busy, done;

  int n_pass = 0;
  int n_total = 0;

  logic q_bits[$], q_done[$], q_ready[$];
  logic exp_bits[$], exp_done[$];
  int   q_match[$];
  int   busy_low;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_count (load_count),
    .load_ready (load_ready),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pk(input logic q[$]);
    logic [255:0] v = '0;
    for (int i = 0; i < q.size() && i < 256; i++) v[i] = q[i];
    return v;
  endfunction

  // Expected line content: each repetition is the word MSB-first; done marks the final bit of the frame.
  function automatic void add_frame(input logic [7:0] d, input logic [3:0] c);
    int reps = (c == 0) ? 1 : int'(c);
    for (int r = 0; r < reps; r++)
      for (int b = 7; b >= 0; b--) begin
        exp_bits.push_back(d[b]);
        exp_done.push_back((r == reps - 1) && (b == 0));
      end
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] c);
    load_valid = 1'b1;
    load_data  = d;
    load_count = c;
    tick();
    load_valid = 1'b0;
  endtask

  // Records the line while out_valid is high; optionally chains a frame on the first ready cycle or aborts at a bit.
  task automatic collect(input bit chain_en, input logic [7:0] cdata, input logic [3:0] ccnt,
                         input int abort_at);
    bit         chained = 1'b0;
    int         n = 0;
    logic [7:0] win = '0;
    q_bits.delete(); q_done.delete(); q_ready.delete(); q_match.delete();
    busy_low = 0;
    while (out_valid === 1'b1 && n < 400) begin
      q_bits.push_back(out);
      q_done.push_back(done);
      q_ready.push_back(load_ready);
      if (busy !== 1'b1) busy_low++;
      win = {win[6:0], out};
      if (n >= 7 && win == PATTERN_58) q_match.push_back(n);
      if (chain_en && !chained && load_ready === 1'b1) begin
        load_valid = 1'b1;
        load_data  = cdata;
        load_count = ccnt;
        chained    = 1'b1;
      end
      if (n == abort_at) abort = 1'b1;
      tick();
      load_valid = 1'b0;
      abort      = 1'b0;
      n++;
    end
    n_total++;
    if (n >= 400) $display("FAIL collect_timeout: ran %0d cycles, limit 400", n);
    else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({out, out_valid, busy, done, load_ready} !== 5'b00001)
      $display("FAIL reset_outputs: got %b, want 00001", {out, out_valid, busy, done, load_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_total++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_reset_ready: got ready=%b valid=%b, want 1 0", load_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    exp_bits.delete(); exp_done.delete();
    add_frame(PATTERN_58, 4'd1);
    send(PATTERN_58, 4'd1);
    collect(1'b0, 8'h00, 4'd0, -1);
    n_total++;
    if (q_bits.size() != 8 || pk(q_bits) !== pk(exp_bits))
      $display("FAIL single_bits: got %0d bits %h, want 8 bits %h", q_bits.size(), pk(q_bits), pk(exp_bits));
    else n_pass++;
    n_total++;
    if (pk(q_done) !== pk(exp_done))
      $display("FAIL single_done: got %h, want %h", pk(q_done), pk(exp_done));
    else n_pass++;
    n_total++;
    if (pk(q_ready) !== pk(exp_done))
      $display("FAIL single_ready: got %h, want %h", pk(q_ready), pk(exp_done));
    else n_pass++;
    n_total++;
    if (busy_low != 0 || busy !== 1'b0 || out !== 1'b0)
      $display("FAIL single_busy: busy_low=%0d busy_after=%b out_after=%b, want 0 0 0", busy_low, busy, out);
    else n_pass++;
  endtask

  task automatic test_repeat();
    logic [7:0] d;
    logic [3:0] c;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? PATTERN_58 : 8'($urandom);
      c = (it == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      exp_bits.delete(); exp_done.delete();
      add_frame(d, c);
      send(d, c);
      collect(1'b0, 8'h00, 4'd0, -1);
      n_total++;
      if (q_bits.size() != exp_bits.size() || pk(q_bits) !== pk(exp_bits) || pk(q_done) !== pk(exp_done))
        $display("FAIL repeat_%0h_x%0d: got %0d bits %h done %h, want %0d bits %h done %h", d, c,
                 q_bits.size(), pk(q_bits), pk(q_done), exp_bits.size(), pk(exp_bits), pk(exp_done));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_count_zero();
    exp_bits.delete(); exp_done.delete();
    add_frame(8'hFF, 4'd0);
    send(8'hFF, 4'd0);
    collect(1'b0, 8'h00, 4'd0, -1);
    n_total++;
    if (q_bits.size() != 8 || pk(q_bits) !== pk(exp_bits) || pk(q_done) !== pk(exp_done))
      $display("FAIL count_zero: got %0d bits %h done %h, want 8 bits %h done %h",
               q_bits.size(), pk(q_bits), pk(q_done), pk(exp_bits), pk(exp_done));
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d2;
    logic [3:0] c1, c2;
    for (int it = 0; it < 2; it++) begin
      c1 = (it == 0) ? 4'd1 : 4'($urandom_range(1, 4));
      d2 = (it == 0) ? PATTERN_58 : 8'($urandom);
      c2 = (it == 0) ? 4'd1 : 4'($urandom_range(0, 4));
      exp_bits.delete(); exp_done.delete();
      add_frame(8'hA5, c1);
      add_frame(d2, c2);
      send(8'hA5, c1);
      collect(1'b1, d2, c2, -1);
      n_total++;
      if (q_bits.size() != exp_bits.size() || pk(q_bits) !== pk(exp_bits))
        $display("FAIL chain_bits_%0d: got %0d bits %h, want %0d bits %h", it,
                 q_bits.size(), pk(q_bits), exp_bits.size(), pk(exp_bits));
      else n_pass++;
      n_total++;
      if (pk(q_done) !== pk(exp_done) || busy_low != 0)
        $display("FAIL chain_done_%0d: got done %h busy_low %0d, want done %h busy_low 0", it,
                 pk(q_done), busy_low, pk(exp_done));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    send(PATTERN_58, 4'd2);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({out, out_valid, busy, done, load_ready} !== 5'b00001)
      $display("FAIL async_reset: got %b, want 00001", {out, out_valid, busy, done, load_ready});
    else n_pass++;
    #1 rst = 1'b0;
    tick();
    exp_bits.delete(); exp_done.delete();
    add_frame(8'h0F, 4'd1);
    send(8'h0F, 4'd1);
    collect(1'b0, 8'h00, 4'd0, -1);
    n_total++;
    if (q_bits.size() != 8 || pk(q_bits) !== pk(exp_bits) || pk(q_done) !== pk(exp_done))
      $display("FAIL after_reset_frame: got %0d bits %h done %h, want 8 bits %h done %h",
               q_bits.size(), pk(q_bits), pk(q_done), pk(exp_bits), pk(exp_done));
    else n_pass++;
    tick();
  endtask

  task automatic test_loopback_abort();
    send(PATTERN_58, 4'd2);
    collect(1'b0, 8'h00, 4'd0, -1);
    n_total++;
    if (q_match.size() != 2 || q_match[0] != 7 || q_match[1] != 15)
      $display("FAIL loopback_matches: got %0d matches first at %0d, want 2 at bits 7 and 15",
               q_match.size(), (q_match.size() > 0) ? q_match[0] : -1);
    else n_pass++;
    tick();
    send(PATTERN_58, 4'd1);
    collect(1'b0, 8'h00, 4'd0, 4);
    n_total++;
    if (q_bits.size() != 5 || pk(q_done) !== '0 || q_match.size() != 0 || out !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_frame: got %0d bits done %h matches %0d out %b busy %b, want 5 0 0 0 0",
               q_bits.size(), pk(q_done), q_match.size(), out, busy);
    else n_pass++;
    tick();
    // Abort on the last-bit cycle must block a chaining load.
    send(PATTERN_58, 4'd1);
    for (int i = 0; i < 7; i++) tick();
    abort = 1'b1;
    load_valid = 1'b1;
    load_data = 8'h0F;
    load_count = 4'd1;
    #1;
    n_total++;
    if (load_ready !== 1'b0)
      $display("FAIL abort_blocks_ready: got %b, want 0", load_ready);
    else n_pass++;
    tick();
    abort = 1'b0;
    load_valid = 1'b0;
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL abort_blocks_load: got busy=%b valid=%b, want 0 0", busy, out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    tick();
    test_repeat();
    test_count_zero();
    test_back_to_back();
    test_async_reset();
    test_loopback_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
